// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared icache constants, FSM encoding and instruction helpers
package icache_pkg;

  localparam int ICACHE_INDEX_WIDTH = 6;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } icache_state_e;

  function automatic logic is_compressed(input logic [31:0] inst);
    return inst[1:0] != 2'b11;
  endfunction

  // Compressed instructions are stored with the upper halfword cleared.
  function automatic logic [31:0] pack_inst(input logic [31:0] inst);
    return is_compressed(inst) ? {16'h0000, inst[15:0]} : inst;
  endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped tag/data storage, async read, sync write
module icache_array #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 25
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  input  logic [TAG_WIDTH-1:0]   rd_tag,
  output logic                   rd_hit,
  output logic [31:0]            rd_data,
  output logic                   rd_is_c,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [31:0]            wr_data,
  input  logic                   wr_is_c
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [ENTRIES];
  logic [31:0]          data_q [ENTRIES];
  logic [ENTRIES-1:0]   is_c_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Payload needs no reset: it is never observed while its valid bit is clear.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
      is_c_q[wr_index] <= wr_is_c;
    end
  end

  assign rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
  assign rd_data = data_q[rd_index];
  assign rd_is_c = is_c_q[rd_index];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache between fetch and mem_unit
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  need_flush_in,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  if_ready,
  output logic                  inst_valid,
  output logic [31:0]           inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_is_c,
  output logic                  ic_valid,
  output logic [ADDR_WIDTH-1:0] ic_aout,
  input  logic                  mem_iout_ready,
  input  logic [31:0]           mem_out
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 1;

  icache_state_e         state_q;
  logic [ADDR_WIDTH-1:0] miss_pc_q;
  logic                  inst_valid_q;
  logic [31:0]           inst_out_q;
  logic [ADDR_WIDTH-1:0] inst_pc_q;
  logic                  inst_is_c_q;

  logic        rd_hit;
  logic [31:0] rd_data;
  logic        rd_is_c;
  logic        fill_en;
  logic [31:0] fill_data;
  logic        fill_is_c;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = if_pc[0] ^ miss_pc_q[0];

  // A fill lands even under flush: the returned data is still correct for miss_pc.
  assign fill_en   = rdy_in && (state_q == ICACHE_MISS) && mem_iout_ready;
  assign fill_data = pack_inst(mem_out);
  assign fill_is_c = is_compressed(mem_out);

  icache_array #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_array (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .rd_index(if_pc[INDEX_WIDTH:1]),
    .rd_tag  (if_pc[ADDR_WIDTH-1:INDEX_WIDTH+1]),
    .rd_hit  (rd_hit),
    .rd_data (rd_data),
    .rd_is_c (rd_is_c),
    .wr_en   (fill_en),
    .wr_index(miss_pc_q[INDEX_WIDTH:1]),
    .wr_tag  (miss_pc_q[ADDR_WIDTH-1:INDEX_WIDTH+1]),
    .wr_data (fill_data),
    .wr_is_c (fill_is_c)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ICACHE_IDLE;
      miss_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      inst_is_c_q  <= 1'b0;
    end else if (rdy_in) begin
      if (need_flush_in) begin
        state_q      <= ICACHE_IDLE;
        inst_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ICACHE_IDLE: begin
            inst_valid_q <= 1'b0;
            if (if_valid) begin
              if (rd_hit) begin
                inst_valid_q <= 1'b1;
                inst_out_q   <= rd_data;
                inst_pc_q    <= if_pc;
                inst_is_c_q  <= rd_is_c;
              end else begin
                miss_pc_q <= if_pc;
                state_q   <= ICACHE_MISS;
              end
            end
          end
          ICACHE_MISS: begin
            inst_valid_q <= 1'b0;
            if (mem_iout_ready) begin
              inst_valid_q <= 1'b1;
              inst_out_q   <= fill_data;
              inst_pc_q    <= miss_pc_q;
              inst_is_c_q  <= fill_is_c;
              state_q      <= ICACHE_IDLE;
            end
          end
          default: state_q <= ICACHE_IDLE;
        endcase
      end
    end
  end

  // Dropping ic_valid in the done cycle keeps mem_unit from launching a duplicate fetch.
  assign ic_valid   = (state_q == ICACHE_MISS) && !mem_iout_ready;
  assign ic_aout    = miss_pc_q;
  assign if_ready   = (state_q == ICACHE_IDLE);
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
  assign inst_is_c  = inst_is_c_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed vector bench for icache
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        need_flush_in;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_is_c;
  logic        ic_valid;
  logic [31:0] ic_aout;
  logic        mem_iout_ready;
  logic [31:0] mem_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  icache #(.INDEX_WIDTH(6), .ADDR_WIDTH(32)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .need_flush_in (need_flush_in),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_ready      (if_ready),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .inst_is_c     (inst_is_c),
    .ic_valid      (ic_valid),
    .ic_aout       (ic_aout),
    .mem_iout_ready(mem_iout_ready),
    .mem_out       (mem_out)
  );

  typedef struct {
    logic        rdy;
    logic        flush;
    logic        req;
    logic [31:0] pc;
    logic        mrdy;
    logic [31:0] mdata;
    logic        e_icv;
    logic [31:0] e_aout;
    logic        e_ifr;
    logic        e_iv;
    logic [31:0] e_out;
    logic [31:0] e_pc;
    logic        e_isc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rdy, input logic flush, input logic req,
                              input logic [31:0] pc, input logic mrdy, input logic [31:0] mdata,
                              input logic e_icv, input logic [31:0] e_aout, input logic e_ifr,
                              input logic e_iv, input logic [31:0] e_out, input logic [31:0] e_pc,
                              input logic e_isc);
    vec_t v;
    v.rdy = rdy; v.flush = flush; v.req = req; v.pc = pc; v.mrdy = mrdy; v.mdata = mdata;
    v.e_icv = e_icv; v.e_aout = e_aout; v.e_ifr = e_ifr;
    v.e_iv = e_iv; v.e_out = e_out; v.e_pc = e_pc; v.e_isc = e_isc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive at negedge, check combinational outputs, then check registers after the edge.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk_in);
    rdy_in = v.rdy; need_flush_in = v.flush; if_valid = v.req; if_pc = v.pc;
    mem_iout_ready = v.mrdy; mem_out = v.mdata;
    #1;
    check({tag, "_ic_valid"}, {31'b0, ic_valid}, {31'b0, v.e_icv});
    check({tag, "_if_ready"}, {31'b0, if_ready}, {31'b0, v.e_ifr});
    if (v.e_icv) check({tag, "_ic_aout"}, ic_aout, v.e_aout);
    @(posedge clk_in);
    #1;
    check({tag, "_inst_valid"}, {31'b0, inst_valid}, {31'b0, v.e_iv});
    if (v.e_iv) begin
      check({tag, "_inst_out"}, inst_out, v.e_out);
      check({tag, "_inst_pc"}, inst_pc, v.e_pc);
      check({tag, "_inst_is_c"}, {31'b0, inst_is_c}, {31'b0, v.e_isc});
    end
  endtask

  localparam logic [31:0] I32 = 32'h00A00093;
  localparam logic [31:0] IC  = 32'h00004501;
  localparam logic [31:0] I3K = 32'h00628293;
  localparam logic [31:0] NOP = 32'h00000013;

  initial begin
    //             rdy fl req pc            mrdy mdata  icv aout          ifr iv out  pc            isc
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,    0, 0,            1, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 1, 32'h1000,     0, 0,    0, 0,            1, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,    1, 32'h1000,     0, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,    1, 32'h1000,     0, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, I32,  0, 0,            0, 1, I32, 32'h1000,     0));
    tbl.push_back(mk(1, 0, 1, 32'h1000,     0, 0,    0, 0,            1, 1, I32, 32'h1000,     0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,    0, 0,            1, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 1, 32'h1002,     0, 0,    0, 0,            1, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, IC,   0, 0,            0, 1, IC,  32'h1002,     1));
    tbl.push_back(mk(1, 0, 1, 32'h1002,     0, 0,    0, 0,            1, 1, IC,  32'h1002,     1));
    tbl.push_back(mk(1, 0, 1, 32'h1000,     0, 0,    0, 0,            1, 1, I32, 32'h1000,     0));
    tbl.push_back(mk(1, 0, 1, 32'h2000,     0, 0,    0, 0,            1, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,    1, 32'h2000,     0, 0, 0,   0,            0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 0,    1, 32'h2000,     0, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,    0, 0,            1, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 1, 32'h2000,     0, 0,    0, 0,            1, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,    1, 32'h2000,     0, 0, 0,   0,            0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 0,    1, 32'h2000,     0, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 1, 32'h3000,     0, 0,    0, 0,            1, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,    1, 32'h3000,     0, 0, 0,   0,            0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, I3K,  0, 0,            0, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 1, 32'h3000,     0, 0,    0, 0,            1, 1, I3K, 32'h3000,     0));
    tbl.push_back(mk(1, 0, 1, 32'h1000,     0, 0,    0, 0,            1, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, I32,  0, 0,            0, 1, I32, 32'h1000,     0));
    tbl.push_back(mk(1, 0, 1, 32'h1080,     0, 0,    0, 0,            1, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, NOP,  0, 0,            0, 1, NOP, 32'h1080,     0));
    tbl.push_back(mk(1, 0, 1, 32'h1000,     0, 0,    0, 0,            1, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, I32,  0, 0,            0, 1, I32, 32'h1000,     0));
    tbl.push_back(mk(1, 0, 1, 32'h1080,     0, 0,    0, 0,            1, 0, 0,   0,            0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, NOP,  0, 0,            0, 0, 0,   0,            0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0,    1, 32'h1080,     0, 0, 0,   0,            0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, NOP,  0, 0,            0, 1, NOP, 32'h1080,     0));
    tbl.push_back(mk(1, 0, 1, 32'h1080,     0, 0,    0, 0,            1, 1, NOP, 32'h1080,     0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0,    0, 0,            1, 1, NOP, 32'h1080,     0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,    0, 0,            1, 0, 0,   0,            0));

    rst_n_in = 1'b0; rdy_in = 1'b1; need_flush_in = 1'b0; if_valid = 1'b0;
    if_pc = '0; mem_iout_ready = 1'b0; mem_out = '0;
    #3;
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst_out", inst_out, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_is_c", {31'b0, inst_is_c}, 32'd0);
    check("rst_ic_valid", {31'b0, ic_valid}, 32'd0);
    check("rst_if_ready", {31'b0, if_ready}, 32'd1);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);

    // Asynchronous reset in the middle of a miss, then a previously valid PC misses.
    apply("ar_hit", mk(1, 0, 1, 32'h1002, 0, 0, 0, 0, 1, 1, IC, 32'h1002, 1));
    apply("ar_miss", mk(1, 0, 1, 32'h2000, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    @(negedge clk_in);
    if_valid = 1'b0;
    #1;
    check("ar_pre_ic_valid", {31'b0, ic_valid}, 32'd1);
    #1 rst_n_in = 1'b0;
    #1;
    check("ar_ic_valid", {31'b0, ic_valid}, 32'd0);
    check("ar_if_ready", {31'b0, if_ready}, 32'd1);
    check("ar_ic_aout", ic_aout, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    apply("ar_refetch", mk(1, 0, 1, 32'h1002, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    apply("ar_wait", mk(1, 0, 0, 32'h0, 0, 0, 1, 32'h1002, 0, 0, 0, 0, 0));
    apply("ar_fill", mk(1, 0, 0, 32'h0, 1, IC, 0, 0, 0, 1, IC, 32'h1002, 1));
    apply("ar_rehit", mk(1, 0, 1, 32'h1002, 0, 0, 0, 0, 1, 1, IC, 32'h1002, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
